tx_stream_fifo: RTL and testbench



---
 rtl/tx_stream_fifo.sv | 118 +++++++++++
 tb/tb_tx_stream_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tx_stream_fifo
//  Purpose  : Parametrised transmit FIFO between the transmit data source and
//             the link serialiser. WIDTH-bit words pass through a DEPTH-entry
//             circular buffer with valid/ready handshakes on both sides,
//             first-word fall-through output, a fill level, synchronous
//             flush and a selectable full policy (backpressure, or
//             drop-with-sticky-overflow).
//  Ports    : clk       - rising-edge clock
//             rst_n     - asynchronous active-low reset
//             flush     - synchronous clear of contents and flags
//             in_valid  - producer presents in_data
//             in_data   - word to enqueue
//             in_ready  - buffer accepts (push = in_valid & in_ready)
//             out_valid - out_data holds the oldest word
//             out_data  - head word, 0 when out_valid is low
//             out_ready - consumer takes word (pop = out_valid & out_ready)
//             level     - number of stored words, 0..DEPTH
//             overflow  - sticky flag for a discarded write (DROP_MODE=1)
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module tx_stream_fifo #(
    parameter int WIDTH     = 5,
    parameter int DEPTH     = 4,
    parameter int DROP_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Storage array; deliberately not reset, it is never read while empty.
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_in_ready;
    logic             w_drop;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW]     != r_rd_ptr[AW]);

    generate
        if (DROP_MODE != 0) begin : g_drop
            // Producer is never stalled; a word offered while full is lost
            // and recorded in the sticky overflow flag.
            assign w_in_ready = 1'b1;
            assign w_drop     = in_valid && w_full;
        end else begin : g_backpressure
            // Held low through reset; deliberately independent of out_ready
            // so no ready path runs from consumer to producer.
            assign w_in_ready = rst_n && !w_full;
            assign w_drop     = 1'b0;
        end
    endgenerate

    // The !w_full term matters only in drop mode, where in_ready stays high.
    assign w_push = in_valid && w_in_ready && !w_full;
    assign w_pop  = !w_empty && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            // Flush wins over any concurrent push/pop/drop.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    // Modulo-2*DEPTH difference of the pointers is exactly the fill count.
    assign level     = r_wr_ptr - r_rd_ptr;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tx_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_stream_fifo
//  Purpose  : Directed self-checking bench for tx_stream_fifo. One instance
//             in backpressure mode, one in drop mode, sharing clk and rst_n.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_stream_fifo;

    logic       clk;
    logic       rst_n;

    logic       flush, in_valid, out_ready;
    logic [4:0] in_data;
    logic       in_ready, out_valid, overflow;
    logic [4:0] out_data;
    logic [2:0] level;

    logic       d_flush, d_in_valid, d_out_ready;
    logic [4:0] d_in_data;
    logic       d_in_ready, d_out_valid, d_overflow;
    logic [4:0] d_out_data;
    logic [2:0] d_level;

    int checks = 0;
    int errors = 0;

    tx_stream_fifo #(.WIDTH(5), .DEPTH(4), .DROP_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .overflow(overflow)
    );

    tx_stream_fifo #(.WIDTH(5), .DEPTH(4), .DROP_MODE(1)) dut_drop (
        .clk(clk), .rst_n(rst_n), .flush(d_flush),
        .in_valid(d_in_valid), .in_data(d_in_data), .in_ready(d_in_ready),
        .out_valid(d_out_valid), .out_data(d_out_data), .out_ready(d_out_ready),
        .level(d_level), .overflow(d_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
        d_flush = 0; d_in_valid = 0; d_out_ready = 0; d_in_data = '0;
        #2;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 5'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_bp: got %b expected 0", in_ready); end
        checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_drop: got %b expected 1", d_in_ready); end
        #10 rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_fill_backpressure();
        out_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1; in_data = 5'(i);
            step();
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d expected 4", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_data !== 5'h01) begin errors++; $display("FAIL fill_head: got %h expected 01", out_data); end
        in_data = 5'h05;
        step();
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL held_off_level: got %0d expected 4", level); end
        out_ready = 1;
        step();
        // Pop of 0x01 at this edge; 0x05 refused because in_ready was low.
        checks++; if (out_data !== 5'h02) begin errors++; $display("FAIL drain1_data: got %h expected 02", out_data); end
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL drain1_level: got %0d expected 3", level); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain1_in_ready: got %b expected 1", in_ready); end
        step();
        // Pop 0x02, push 0x05.
        in_valid = 0;
        checks++; if (out_data !== 5'h03) begin errors++; $display("FAIL drain2_data: got %h expected 03", out_data); end
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL drain2_level: got %0d expected 3", level); end
        step();
        checks++; if (out_data !== 5'h04) begin errors++; $display("FAIL drain3_data: got %h expected 04", out_data); end
        step();
        checks++; if (out_data !== 5'h05) begin errors++; $display("FAIL drain4_data: got %h expected 05", out_data); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL drain4_level: got %0d expected 1", level); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid: got %b expected 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL drain_empty_level: got %0d expected 0", level); end
        out_ready = 0;
    endtask

    task automatic test_single_push();
        in_valid = 1; in_data = 5'h1F; out_ready = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_comb_path: got %b expected 0", out_valid); end
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 5'h1F) begin errors++; $display("FAIL single_data: got %h expected 1f", out_data); end
        out_ready = 1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 5'h00) begin errors++; $display("FAIL single_pop_data: got %h expected 00", out_data); end
        out_ready = 0;
    endtask

    task automatic test_back_to_back();
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            in_data = 5'(i);
            step();
            checks++;
            if (out_data !== 5'(i) || level !== 3'd1) begin
                errors++;
                $display("FAIL stream_%0d: got data %h level %0d expected data %h level 1", i, out_data, level, 5'(i));
            end
        end
        in_valid = 0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid: got %b expected 0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_drop_mode();
        d_out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            d_in_valid = 1; d_in_data = 5'(8'h0A + i);
            step();
        end
        checks++; if (d_overflow !== 1'b0) begin errors++; $display("FAIL drop_pre_overflow: got %b expected 0", d_overflow); end
        checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL drop_full_in_ready: got %b expected 1", d_in_ready); end
        d_in_data = 5'h0E;
        step();
        d_in_valid = 0;
        checks++; if (d_overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow: got %b expected 1", d_overflow); end
        checks++; if (d_level !== 3'd4) begin errors++; $display("FAIL drop_level: got %0d expected 4", d_level); end
        d_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (d_out_data !== 5'(8'h0A + i)) begin
                errors++;
                $display("FAIL drop_drain_%0d: got %h expected %h", i, d_out_data, 5'(8'h0A + i));
            end
            step();
        end
        checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL drop_drain_empty: got %b expected 0", d_out_valid); end
        checks++; if (d_overflow !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b expected 1", d_overflow); end
        // Flush clears the sticky flag and overrides a concurrent push.
        d_flush = 1; d_in_valid = 1; d_in_data = 5'h11;
        step();
        d_flush = 0; d_in_valid = 0; d_out_ready = 0;
        checks++; if (d_overflow !== 1'b0) begin errors++; $display("FAIL drop_flush_overflow: got %b expected 0", d_overflow); end
        checks++; if (d_level !== 3'd0) begin errors++; $display("FAIL drop_flush_level: got %0d expected 0", d_level); end
    endtask

    task automatic test_flush();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = 5'(8'h10 + i);
            step();
        end
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_pre_level: got %0d expected 3", level); end
        flush = 1; in_valid = 1; out_ready = 1; in_data = 5'h15;
        step();
        flush = 0; in_valid = 0;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b expected 0", overflow); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_word_gone: got %b expected 0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        in_valid = 1; in_data = 5'h03; step();
        in_data = 5'h04; step();
        in_valid = 0;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL areset_pre_level: got %0d expected 2", level); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL areset_level: got %0d expected 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 5'h00) begin errors++; $display("FAIL areset_data: got %h expected 00", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready: got %b expected 0", in_ready); end
        #2 rst_n = 1'b1;
        in_valid = 1; in_data = 5'h07;
        step();
        in_valid = 0;
        checks++; if (out_data !== 5'h07) begin errors++; $display("FAIL areset_first_out: got %h expected 07", out_data); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL areset_first_level: got %0d expected 1", level); end
    endtask

    initial begin
        test_reset();
        test_fill_backpressure();
        test_single_push();
        test_back_to_back();
        test_drop_mode();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
